// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the IF/ID queue
interface if_id_queue_if #(
   parameter int DW = 32,
   parameter int AW = 30
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_instr;
   logic [AW-1:0] in_pc;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_instr;
   logic [AW-1:0] out_pc4;
   logic          flush;

   modport master (
      output in_valid, in_instr, in_pc, out_ready, flush,
      input  in_ready, out_valid, out_instr, out_pc4
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready, flush,
      output in_ready, out_valid, out_instr, out_pc4
   );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - DEPTH-entry first-word-fall-through IF/ID buffer with flush
module if_id_queue #(
   parameter int            DW     = 32,
   parameter int            AW     = 30,
   parameter int            DEPTH  = 2,
   parameter logic [DW-1:0] BUBBLE = '0,
   localparam int           PW     = $clog2(DEPTH),
   localparam int           CW     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   if_id_queue_if.slave     q,
   output logic [CW-1:0]    count,
   output logic [15:0]      flush_drops
);
   logic [DW-1:0] mem_instr [DEPTH];
   logic [AW-1:0] mem_pc4   [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          not_full;
   logic          not_empty;
   logic          push;
   logic          pop;
   logic [16:0]   drops_sum;
   logic [15:0]   drops_next;

   // ready depends on state only, so decode stalls never reach fetch combinationally
   assign not_full  = (count != CW'(DEPTH));
   assign not_empty = (count != '0);
   assign push      = q.in_valid & not_full;
   assign pop       = not_empty & q.out_ready;

   assign q.in_ready  = not_full;
   assign q.out_valid = not_empty;
   assign q.out_instr = not_empty ? mem_instr[rd_ptr] : BUBBLE;
   assign q.out_pc4   = not_empty ? mem_pc4[rd_ptr]   : '0;

   assign drops_sum  = {1'b0, flush_drops} + 17'(count);
   assign drops_next = drops_sum[16] ? 16'hFFFF : drops_sum[15:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         flush_drops <= '0;
      end else if (q.flush) begin
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         flush_drops <= drops_next;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   // payload storage carries no reset; occupancy alone decides what is visible
   always_ff @(posedge clk) begin
      if (push && !q.flush) begin
         mem_instr[wr_ptr] <= q.in_instr;
         mem_pc4[wr_ptr]   <= q.in_pc + AW'(1);
      end
   end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction-fetch to decode buffer. It replaces the single IF/ID instruction register with a DEPTH-entry first-word-fall-through queue. Each entry holds {instr, PC+1}. Fetch and decode are coupled by valid/ready handshakes, and a flush input lets branch and jump redirects discard wrong-path instructions. It sits between instruction memory and the decode stage of the MIPS pipeline.

## Interface
- DW, 32: instruction width in bits.
- AW, 30: word-address width; carries PC[31:2].
- DEPTH, 2: number of entries; power of two, at least 2.
- BUBBLE, 0: instruction value driven on out_instr when the queue is empty (NOP).

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an instruction this cycle.
- in_instr  in  DW  instruction word from instruction memory.
- in_pc  in  AW  word address of in_instr.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head entry this cycle.
- out_instr  out  DW  head instruction, or BUBBLE when empty.
- out_pc4  out  AW  head PC+1, or 0 when empty.
- flush  in  1  discard all entries (redirect).
- count  out  $clog2(DEPTH+1)  current occupancy.
- flush_drops  out  16  saturating count of valid entries discarded by flushes.

## Operation
- Storage: DEPTH-entry circular buffer with rd_ptr, wr_ptr and count registers.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- On push, the entry written is {in_instr, in_pc + 1}, with the add truncated to AW bits. in_pc = all-ones therefore stores 0.
- in_ready = (count != DEPTH). It depends only on state, never on out_ready, so there is no combinational ready path.
- out_valid = (count != 0).
- out_instr and out_pc4 show the head entry when out_valid=1. Otherwise they show BUBBLE and 0.
- Simultaneous push and pop when neither full nor empty: both happen; count is unchanged; both pointers advance.
- Push while full: cannot occur, because in_ready=0. When full and out_ready=1, a pop happens this cycle and in_ready rises on the next cycle.
- Pop while empty: cannot occur, because out_valid=0.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Sets count=0, rd_ptr=wr_ptr=0.
  - Drops the incoming word even if in_valid=1.
  - Adds the pre-flush count to flush_drops; saturates at 16'hFFFF.
- Storage array contents are not reset and need no reset.

## Timing
- Reset (async assert, immediate effect):
  - count=0, pointers=0, flush_drops=0.
  - out_valid=0, out_instr=BUBBLE, out_pc4=0, in_ready=1.
- Reset deasserting mid-operation: the queue restarts empty. Nothing pushed before reset is ever presented.
- Latency: a word pushed on edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle bypass when the queue is empty.
- Throughput: one push and one pop per cycle in steady state when DEPTH≥2.
- Flush asserted on edge N: out_valid=0 from cycle N+1. A push in cycle N+1 is accepted normally.
- out_* hold steady while out_valid=1 and out_ready=0 (decode stall).

## Test plan
- Reset with DEPTH=2:
  - Stimulus: assert rst mid-cycle.
  - Required: out_valid=0, out_instr=0, out_pc4=0, in_ready=1, count=0 immediately, without waiting for clk.
- Fill and drain:
  - Stimulus: push {0x8C010004, pc 0x100} then {0x00221820, pc 0x101} with out_ready=0.
  - Required: count=2, in_ready=0, out_instr=0x8C010004, out_pc4=0x101.
  - Then raise out_ready for 2 cycles. Required: second beat shows 0x00221820 with pc4 0x102, then out_valid=0.
- Streaming:
  - Stimulus: in_valid=1 and out_ready=1 for 10 cycles, pcs 0x200..0x209.
  - Required: one output per cycle after 1-cycle latency; pc4 values 0x201..0x20A in order; count never exceeds 1.
- Wrap:
  - Stimulus: push with in_pc=30'h3FFFFFFF.
  - Required: out_pc4=0.
  - Also required: 3·DEPTH push/pop cycles wrap the pointers with no reordering.
- Flush priority:
  - Stimulus: with count=2, assert flush, in_valid=1 and out_ready=1 together.
  - Required: next cycle count=0, out_instr=BUBBLE, flush_drops=2, incoming word absent.
- Stall hold:
  - Stimulus: out_ready=0 for 5 cycles with 1 entry present.
  - Required: out_instr and out_pc4 constant, count=1.
  - Then with DEPTH=4, push 3 more. Required: count=4, in_ready=0.
